blur_frame_sequencer: RTL and testbench

//  Sequences one 3x3 Gaussian-blur pass over a greyscale frame held in block RAM.

---
 rtl/blur_frame_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_blur_frame_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/blur_frame_sequencer.sv
// blur_frame_sequencer: address/strobe sequencer for one 3x3 blur pass over a BRAM frame.
// Reads rows y-1/y/y+1 in lockstep, delays the read strobe into a window-shift strobe,
// and delays a tagged write address so results land on the window centre.
module blur_frame_sequencer #(
    parameter int IMG_W    = 252,
    parameter int IMG_H    = 156,
    parameter int ADDR_W   = 16,
    parameter int RD_LAT   = 2,
    parameter int KERN_LAT = 0
) (
    input  logic              PixelClk,
    input  logic              nRST,
    input  logic              start_i,
    input  logic              abort_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              frame_ready_o,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_top_o,
    output logic [ADDR_W-1:0] rd_addr_mid_o,
    output logic [ADDR_W-1:0] rd_addr_bot_o,
    output logic              win_shift_o,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o
);

    localparam int DLY = RD_LAT + KERN_LAT;
    localparam int XW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int CW  = (DLY > 1) ? $clog2(DLY) : 1;

    localparam logic [XW-1:0]     X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0]     Y_LAST = YW'(IMG_H - 3);
    localparam logic [CW-1:0]     C_LOAD = CW'(DLY - 1);
    localparam logic [ADDR_W-1:0] W_STEP = ADDR_W'(IMG_W);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t            state_q;
    logic              busy_q, done_q, frame_ready_q, rd_en_q;
    logic [ADDR_W-1:0] top_q, mid_q, bot_q;
    logic [XW-1:0]     x_q;
    logic [YW-1:0]     y_q;
    logic [CW-1:0]     cnt_q;

    logic [RD_LAT-1:0] win_sr_q;
    logic [DLY-1:0]    wv_sr_q;
    logic [ADDR_W-1:0] wa_sr_q [DLY];

    logic              flush_d;
    logic              wr_tag_d;
    logic [ADDR_W-1:0] wr_addr_d;

    // Write tag/address captured at read time; untagged reads push zero so idle outputs stay 0.
    always_comb begin
        flush_d   = abort_i && ((state_q == S_RUN) || (state_q == S_DRAIN));
        wr_tag_d  = rd_en_q && (x_q >= XW'(2));
        wr_addr_d = '0;
        if (wr_tag_d) begin
            wr_addr_d = mid_q - ADDR_W'(1);
        end
    end

    // Pass control FSM with registered read addresses and status outputs.
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            state_q       <= S_IDLE;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            frame_ready_q <= 1'b0;
            rd_en_q       <= 1'b0;
            top_q         <= '0;
            mid_q         <= '0;
            bot_q         <= '0;
            x_q           <= '0;
            y_q           <= '0;
            cnt_q         <= '0;
        end else begin
            done_q <= 1'b0;
            if (flush_d) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                rd_en_q <= 1'b0;
                top_q   <= '0;
                mid_q   <= '0;
                bot_q   <= '0;
                x_q     <= '0;
                y_q     <= '0;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start_i && !abort_i) begin
                            state_q       <= S_RUN;
                            busy_q        <= 1'b1;
                            frame_ready_q <= 1'b0;
                            rd_en_q       <= 1'b1;
                            top_q         <= '0;
                            mid_q         <= W_STEP;
                            bot_q         <= W_STEP + W_STEP;
                            x_q           <= '0;
                            y_q           <= '0;
                        end
                    end
                    S_RUN: begin
                        if ((x_q == X_LAST) && (y_q == Y_LAST)) begin
                            state_q <= S_DRAIN;
                            rd_en_q <= 1'b0;
                            cnt_q   <= C_LOAD;
                        end else begin
                            // Addresses are contiguous, so +1 at the row end equals base+IMG_W.
                            top_q <= top_q + ADDR_W'(1);
                            mid_q <= mid_q + ADDR_W'(1);
                            bot_q <= bot_q + ADDR_W'(1);
                            if (x_q == X_LAST) begin
                                x_q <= '0;
                                y_q <= y_q + YW'(1);
                            end else begin
                                x_q <= x_q + XW'(1);
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (cnt_q == '0) begin
                            state_q       <= S_DONE;
                            busy_q        <= 1'b0;
                            done_q        <= 1'b1;
                            frame_ready_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Delay lines: window shift after the BRAM latency, write after BRAM + kernel latency.
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            win_sr_q <= '0;
            wv_sr_q  <= '0;
            for (int unsigned i = 0; i < DLY; i++) begin
                wa_sr_q[i] <= '0;
            end
        end else if (flush_d) begin
            win_sr_q <= '0;
            wv_sr_q  <= '0;
            for (int unsigned i = 0; i < DLY; i++) begin
                wa_sr_q[i] <= '0;
            end
        end else begin
            win_sr_q[0] <= rd_en_q;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                win_sr_q[i] <= win_sr_q[i-1];
            end
            wv_sr_q[0] <= wr_tag_d;
            wa_sr_q[0] <= wr_addr_d;
            for (int unsigned i = 1; i < DLY; i++) begin
                wv_sr_q[i] <= wv_sr_q[i-1];
                wa_sr_q[i] <= wa_sr_q[i-1];
            end
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign frame_ready_o = frame_ready_q;
    assign rd_en_o       = rd_en_q;
    assign rd_addr_top_o = top_q;
    assign rd_addr_mid_o = mid_q;
    assign rd_addr_bot_o = bot_q;
    assign win_shift_o   = win_sr_q[RD_LAT-1];
    assign wr_en_o       = wv_sr_q[DLY-1];
    assign wr_addr_o     = wa_sr_q[DLY-1];

endmodule

// File: tb/tb_blur_frame_sequencer.sv
// Directed bench for blur_frame_sequencer: small 8x5 frame instance plus a default-size instance.
module tb_blur_frame_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic nrst, start_a, abort_a, start_b, abort_b;

    logic        a_busy, a_done, a_fr, a_rd, a_win, a_wr;
    logic [15:0] a_top, a_mid, a_bot, a_wa;
    logic        b_busy, b_done, b_fr, b_rd, b_win, b_wr;
    logic [15:0] b_top, b_mid, b_bot, b_wa;

    int n_cmp = 0;
    int n_mis = 0;

    blur_frame_sequencer #(.IMG_W(8), .IMG_H(5), .ADDR_W(16), .RD_LAT(2), .KERN_LAT(0)) dut_a (
        .PixelClk(clk), .nRST(nrst), .start_i(start_a), .abort_i(abort_a),
        .busy_o(a_busy), .done_o(a_done), .frame_ready_o(a_fr), .rd_en_o(a_rd),
        .rd_addr_top_o(a_top), .rd_addr_mid_o(a_mid), .rd_addr_bot_o(a_bot),
        .win_shift_o(a_win), .wr_en_o(a_wr), .wr_addr_o(a_wa)
    );

    blur_frame_sequencer #(.IMG_W(252), .IMG_H(156), .ADDR_W(16), .RD_LAT(2), .KERN_LAT(0)) dut_b (
        .PixelClk(clk), .nRST(nrst), .start_i(start_b), .abort_i(abort_b),
        .busy_o(b_busy), .done_o(b_done), .frame_ready_o(b_fr), .rd_en_o(b_rd),
        .rd_addr_top_o(b_top), .rd_addr_mid_o(b_mid), .rd_addr_bot_o(b_bot),
        .win_shift_o(b_win), .wr_en_o(b_wr), .wr_addr_o(b_wa)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_zero(input string tag);
        chk({tag, " flags"}, {58'd0, a_busy, a_done, a_fr, a_rd, a_win, a_wr}, 64'd0);
        chk({tag, " addrs"}, {a_top, a_mid, a_bot, a_wa}, 64'd0);
    endtask

    // Full pass on the 8x5 instance; cycle 0 is the cycle start_i is presented.
    task automatic run_pass(input logic fr0, input string tag);
        int wr_cnt = 0;
        int first_cyc = -1;
        int first_addr = -1;
        int last_addr = -1;
        int bad = 0;
        int seq_err = 0;
        int exp_wa;
        chk({tag, " frame_ready at start"}, a_fr, fr0);
        start_a = 1'b1;
        tick;
        start_a = 1'b0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            chk($sformatf("%s rd_en c%0d", tag, cyc), a_rd, (cyc <= 24));
            chk($sformatf("%s busy c%0d", tag, cyc), a_busy, (cyc <= 26));
            chk($sformatf("%s win_shift c%0d", tag, cyc), a_win, (cyc >= 3 && cyc <= 26));
            chk($sformatf("%s done c%0d", tag, cyc), a_done, (cyc == 27));
            chk($sformatf("%s frame_ready c%0d", tag, cyc), a_fr, (cyc >= 27));
            if (cyc == 1) begin
                chk({tag, " c1 top"}, a_top, 0);
                chk({tag, " c1 mid"}, a_mid, 8);
                chk({tag, " c1 bot"}, a_bot, 16);
            end
            if (cyc == 8) begin
                chk({tag, " c8 top"}, a_top, 7);
                chk({tag, " c8 mid"}, a_mid, 15);
                chk({tag, " c8 bot"}, a_bot, 23);
            end
            if (cyc == 9) begin
                chk({tag, " c9 top"}, a_top, 8);
                chk({tag, " c9 mid"}, a_mid, 16);
                chk({tag, " c9 bot"}, a_bot, 24);
            end
            if (cyc == 24) begin
                chk({tag, " last read bot"}, a_bot, 39);
            end
            if (a_wr === 1'b1) begin
                exp_wa = 8 * (wr_cnt / 6 + 1) + 1 + (wr_cnt % 6);
                if (a_wa != exp_wa[15:0]) seq_err++;
                if (first_cyc < 0) begin
                    first_cyc = cyc;
                    first_addr = int'(a_wa);
                end
                last_addr = int'(a_wa);
                if (a_wa == 8 || a_wa == 15 || a_wa == 16 || a_wa == 23) bad++;
                wr_cnt++;
            end
            tick;
        end
        chk({tag, " first write cycle"}, first_cyc, 5);
        chk({tag, " first write addr"}, first_addr, 9);
        chk({tag, " write count"}, wr_cnt, 18);
        chk({tag, " last write addr"}, last_addr, 30);
        chk({tag, " border writes"}, bad, 0);
        chk({tag, " write order errors"}, seq_err, 0);
    endtask

    initial begin
        int seen;
        int reads, writes, last_rd, last_bot, done_cyc, first_wa;

        nrst = 1'b0;
        start_a = 1'b0; abort_a = 1'b0;
        start_b = 1'b0; abort_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        idle_zero("T1 in reset");
        nrst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick;
            idle_zero("T1 idle");
        end

        run_pass(1'b0, "T2");

        // start and abort together in IDLE: abort wins
        start_a = 1'b1; abort_a = 1'b1;
        tick;
        start_a = 1'b0; abort_a = 1'b0;
        chk("start+abort busy", a_busy, 0);
        chk("start+abort rd_en", a_rd, 0);
        chk("start+abort frame_ready kept", a_fr, 1);

        // T5 abort at cycle 12
        start_a = 1'b1;
        tick;
        start_a = 1'b0;
        chk("T5 frame_ready cleared on start", a_fr, 0);
        chk("T5 c1 rd_en", a_rd, 1);
        repeat (11) tick;
        chk("T5 c12 busy", a_busy, 1);
        abort_a = 1'b1;
        tick;
        abort_a = 1'b0;
        chk("T5 c13 busy", a_busy, 0);
        chk("T5 c13 wr_en", a_wr, 0);
        chk("T5 c13 rd_en", a_rd, 0);
        chk("T5 c13 win_shift", a_win, 0);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (a_done === 1'b1 || a_fr === 1'b1 || a_wr === 1'b1) seen++;
            tick;
        end
        chk("T5 done/frame_ready/wr after abort", seen, 0);
        run_pass(1'b0, "T5 restart");

        // reset in the middle of a pass clears outputs asynchronously
        start_a = 1'b1;
        tick;
        start_a = 1'b0;
        repeat (4) tick;
        chk("mid-pass rd_en before reset", a_rd, 1);
        nrst = 1'b0;
        #1;
        idle_zero("async reset mid-pass");
        tick;
        nrst = 1'b1;
        tick;
        idle_zero("after reset release");

        // T6 default geometry, with an ignored start pulse mid-pass
        reads = 0; writes = 0; last_rd = -1; last_bot = -1; done_cyc = -1; first_wa = -1;
        start_b = 1'b1;
        tick;
        start_b = 1'b0;
        for (int cyc = 1; cyc <= 45000; cyc++) begin
            start_b = (cyc == 1000);
            if (b_rd === 1'b1) begin
                reads++;
                last_rd = cyc;
                last_bot = int'(b_bot);
            end
            if (b_wr === 1'b1) begin
                if (first_wa < 0) first_wa = int'(b_wa);
                writes++;
            end
            if (b_done === 1'b1) begin
                done_cyc = cyc;
                break;
            end
            tick;
        end
        start_b = 1'b0;
        chk("T6 done seen cycle", done_cyc, 38811);
        chk("T6 reads", reads, 38808);
        chk("T6 writes", writes, 38500);
        chk("T6 last read cycle", last_rd, 38808);
        chk("T6 done after last read", done_cyc - last_rd, 3);
        chk("T6 last bot addr", last_bot, 39311);
        chk("T6 first write addr", first_wa, 253);
        chk("T6 frame_ready with done", b_fr, 1);
        tick;
        chk("T6 busy after done", b_busy, 0);
        chk("T6 done one cycle", b_done, 0);
        chk("T6 frame_ready held", b_fr, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
